// File: rtl/nwr_req_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nwr_req_arbiter_if : requester-side and SRIO NWRITE-side bundle            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface nwr_req_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]    req_valid_in;
  logic [NUM_REQ*34-1:0] req_addr_in;
  logic [NUM_REQ*12-1:0] req_tsize_in;
  logic [NUM_REQ*64-1:0] req_tdata_in;
  logic [NUM_REQ*8-1:0]  req_tkeep_in;
  logic [NUM_REQ-1:0]    req_tvalid_in;
  logic [NUM_REQ-1:0]    req_tlast_in;
  logic [NUM_REQ-1:0]    req_tready_o;
  logic [NUM_REQ-1:0]    req_grant_o;
  logic [NUM_REQ-1:0]    req_done_o;
  logic                  nwr_ready_in;
  logic                  nwr_busy_in;
  logic                  nwr_done_in;
  logic                  user_tready_in;
  logic [33:0]           user_addr_o;
  logic [11:0]           user_tsize_o;
  logic [63:0]           user_tdata_o;
  logic                  user_tvalid_o;
  logic [7:0]            user_tkeep_o;
  logic                  user_tlast_o;
  logic                  len_err_o;
  logic                  timeout_err_o;

  modport slave (
    input  req_valid_in, req_addr_in, req_tsize_in, req_tdata_in, req_tkeep_in,
    input  req_tvalid_in, req_tlast_in,
    input  nwr_ready_in, nwr_busy_in, nwr_done_in, user_tready_in,
    output req_tready_o, req_grant_o, req_done_o,
    output user_addr_o, user_tsize_o, user_tdata_o, user_tvalid_o, user_tkeep_o,
    output user_tlast_o, len_err_o, timeout_err_o
  );

  modport master (
    output req_valid_in, req_addr_in, req_tsize_in, req_tdata_in, req_tkeep_in,
    output req_tvalid_in, req_tlast_in,
    output nwr_ready_in, nwr_busy_in, nwr_done_in, user_tready_in,
    input  req_tready_o, req_grant_o, req_done_o,
    input  user_addr_o, user_tsize_o, user_tdata_o, user_tvalid_o, user_tkeep_o,
    input  user_tlast_o, len_err_o, timeout_err_o
  );
endinterface
`default_nettype wire

// File: rtl/nwr_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nwr_req_arbiter : round-robin share of the SRIO NWRITE request port        |
// | Optional macro NWR_TIMEOUT_EN enables the nwr_done watchdog.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nwr_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input wire               log_clk,
  input wire               log_rst,
  nwr_req_arbiter_if.slave io
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [33:0] addr_a  [NUM_REQ];
  logic [11:0] tsize_a [NUM_REQ];
  logic [63:0] tdata_a [NUM_REQ];
  logic [7:0]  tkeep_a [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_a[gi]  = io.req_addr_in[34*gi +: 34];
      assign tsize_a[gi] = io.req_tsize_in[12*gi +: 12];
      assign tdata_a[gi] = io.req_tdata_in[64*gi +: 64];
      assign tkeep_a[gi] = io.req_tkeep_in[8*gi +: 8];
    end
  endgenerate

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [PW-1:0]      gidx_q, gidx_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [33:0]        addr_q, addr_d;
  logic [11:0]        tsize_q, tsize_d;
  logic [9:0]         beats_exp_q, beats_exp_d;
  logic [9:0]         beat_cnt_q, beat_cnt_d;
  logic               len_err_q, len_err_d;

  // First pending requester strictly after the last one served, with wrap.
  logic [PW-1:0] win_idx;
  logic          win_found;
  logic [CW-1:0] cand;
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!win_found && io.req_valid_in[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  logic       stream_w;
  logic       cur_tvalid;
  logic       cur_tlast;
  logic       beat_w;
  logic [9:0] cnt_nxt;
  assign stream_w   = (state_q == STREAM);
  assign cur_tvalid = io.req_tvalid_in[gidx_q];
  assign cur_tlast  = io.req_tlast_in[gidx_q];
  assign beat_w     = stream_w & cur_tvalid & io.user_tready_in;
  assign cnt_nxt    = beat_cnt_q + 10'd1;

`ifdef NWR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_err_q, tmo_err_d;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = |TIMEOUT_CYC;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    tsize_d     = tsize_q;
    beats_exp_d = beats_exp_q;
    beat_cnt_d  = beat_cnt_q;
    len_err_d   = 1'b0;
`ifdef NWR_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (io.nwr_ready_in && !io.nwr_busy_in && win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
          addr_d           = addr_a[win_idx];
          tsize_d          = tsize_a[win_idx];
          beats_exp_d      = {1'b0, tsize_a[win_idx][11:3]} + 10'd1;
          beat_cnt_d       = '0;
          state_d          = GRANT;
        end
      end
      GRANT: state_d = STREAM;
      STREAM: begin
        if (beat_w) begin
          beat_cnt_d = cnt_nxt;
          if (cur_tlast) begin
            len_err_d = (cnt_nxt != beats_exp_q);
            state_d   = WAIT_DONE;
`ifdef NWR_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            // Expected count reached without tlast: flag it but keep streaming.
            len_err_d = (cnt_nxt == beats_exp_q);
          end
        end
      end
      WAIT_DONE: begin
        if (io.nwr_done_in) begin
          done_d  = grant_q;
          ptr_d   = gidx_q;
          grant_d = '0;
          state_d = IDLE;
        end
`ifdef NWR_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          tmo_err_d = 1'b1;
          ptr_d     = gidx_q;
          grant_d   = '0;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      gidx_q      <= '0;
      ptr_q       <= PW'(NUM_REQ - 1);
      addr_q      <= '0;
      tsize_q     <= '0;
      beats_exp_q <= '0;
      beat_cnt_q  <= '0;
      len_err_q   <= 1'b0;
`ifdef NWR_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      tsize_q     <= tsize_d;
      beats_exp_q <= beats_exp_d;
      beat_cnt_q  <= beat_cnt_d;
      len_err_q   <= len_err_d;
`ifdef NWR_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_err_q   <= tmo_err_d;
`endif
    end
  end

  assign io.req_grant_o   = grant_q;
  assign io.req_done_o    = done_q;
  assign io.req_tready_o  = stream_w ? (grant_q & {NUM_REQ{io.user_tready_in}}) : '0;
  assign io.user_addr_o   = addr_q;
  assign io.user_tsize_o  = tsize_q;
  assign io.user_tdata_o  = stream_w ? tdata_a[gidx_q] : '0;
  assign io.user_tkeep_o  = stream_w ? tkeep_a[gidx_q] : '0;
  assign io.user_tvalid_o = stream_w & cur_tvalid;
  assign io.user_tlast_o  = stream_w & cur_tlast;
  assign io.len_err_o     = len_err_q;
`ifdef NWR_TIMEOUT_EN
  assign io.timeout_err_o = tmo_err_q;
`else
  assign io.timeout_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nwr_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nwr_req_arbiter : scoreboard bench for the NWRITE request arbiter       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_nwr_req_arbiter;
  localparam int NUM_REQ = 4;

  logic log_clk = 1'b0;
  logic log_rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   first_gnt_cyc;

  always #5 log_clk = ~log_clk;

  nwr_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  nwr_req_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (4096)
  ) dut (
    .log_clk (log_clk),
    .log_rst (log_rst),
    .io      (bus)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    exp_gnt_q[$];

  int          npkt   [NUM_REQ];
  int          beat   [NUM_REQ];
  int          sent   [NUM_REQ];
  int          pushed [NUM_REQ];
  int          nbeats [NUM_REQ];
  logic [11:0] tsz    [NUM_REQ];
  logic [33:0] adr    [NUM_REQ];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int r, input int p, input int b);
    return {8'(r), 8'(p), 16'hc0de, 32'(b * 32'h0101_0101 + 32'h11)};
  endfunction

  function automatic logic [7:0] kp(input int r, input int b);
    return (b == nbeats[r] - 1) ? 8'h0f : 8'hff;
  endfunction

  task automatic setup(input int r, input logic [11:0] ts, input logic [33:0] a, input int nb);
    tsz[r] = ts; adr[r] = a; nbeats[r] = nb;
  endtask

  task automatic push_packet(input int r);
    for (int b = 0; b < nbeats[r]; b++)
      exp_q.push_back('{d: pat(r, pushed[r], b), k: kp(r, b), l: (b == nbeats[r] - 1)});
    exp_gnt_q.push_back(r);
    pushed[r]++;
    npkt[r]++;
  endtask

  task automatic drive();
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.req_valid_in[r]           = (npkt[r] > 0);
      bus.req_tvalid_in[r]          = (npkt[r] > 0);
      bus.req_tlast_in[r]           = (beat[r] == nbeats[r] - 1);
      bus.req_addr_in[34*r +: 34]   = adr[r];
      bus.req_tsize_in[12*r +: 12]  = tsz[r];
      bus.req_tdata_in[64*r +: 64]  = pat(r, sent[r], beat[r]);
      bus.req_tkeep_in[8*r +: 8]    = kp(r, beat[r]);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    check({tag, "_grant"},  bus.req_grant_o, 0);
    check({tag, "_done"},   bus.req_done_o, 0);
    check({tag, "_tready"}, bus.req_tready_o, 0);
    check({tag, "_addr"},   bus.user_addr_o, 0);
    check({tag, "_tsize"},  bus.user_tsize_o, 0);
    check({tag, "_tdata"},  bus.user_tdata_o, 0);
    check({tag, "_strm"},   {bus.user_tvalid_o, bus.user_tlast_o, bus.user_tkeep_o}, 0);
    check({tag, "_errs"},   {bus.len_err_o, bus.timeout_err_o}, 0);
  endtask

  // Core model: nwr_done_in pulses 3 cycles after the tlast beat is taken.
  task automatic run(input int tmode, input int stop_beats, input int budget);
    int target, dones, acc_beats, done_tmr, cur_g, pk_cnt, pk_exp;
    logic acc, acc_last, done_prev, exp_len;
    logic [NUM_REQ-1:0] gnt, gnt_prev, oh;
    beat_t e;
    target = exp_gnt_q.size(); dones = 0; acc_beats = 0; done_tmr = 0;
    cur_g = 0; pk_cnt = 0; pk_exp = 0;
    acc = 1'b0; acc_last = 1'b0; done_prev = 1'b0; exp_len = 1'b0;
    gnt_prev = '0; first_gnt_cyc = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge log_clk); #1;
      if (acc) begin
        if (acc_last) begin
          beat[cur_g] = 0; sent[cur_g]++; npkt[cur_g]--;
        end else begin
          beat[cur_g]++;
        end
      end
      if (stop_beats > 0 && acc_beats >= stop_beats) return;
      drive();
      bus.user_tready_in = (tmode == 0) || (cyc % 2 == 0);
      bus.nwr_done_in = 1'b0;
      if (done_tmr > 0) begin
        done_tmr--;
        bus.nwr_done_in = (done_tmr == 0);
      end
      #1;
      gnt = bus.req_grant_o;
      oh = done_prev ? gnt_prev : '0;
      check("req_done", bus.req_done_o, oh);
      if (done_prev) dones++;
      check("len_err", bus.len_err_o, exp_len);
      exp_len = 1'b0;
      check("timeout_err", bus.timeout_err_o, 0);
      check("tready_mask", bus.req_tready_o & ~gnt, 0);
      if (gnt == '0) check("tvalid_idle", bus.user_tvalid_o, 0);
      if (gnt != '0 && gnt_prev == '0) begin
        if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
        if (exp_gnt_q.size() == 0) check("grant_unexpected", gnt, 0);
        else begin
          cur_g = exp_gnt_q.pop_front();
          oh = '0; oh[cur_g] = 1'b1;
          check("grant", gnt, oh);
          check("addr", bus.user_addr_o, adr[cur_g]);
          check("tsize", bus.user_tsize_o, tsz[cur_g]);
          pk_cnt = 0;
          pk_exp = int'(tsz[cur_g][11:3]) + 1;
        end
      end
      acc = bus.user_tvalid_o && bus.user_tready_in;
      if (bus.user_tvalid_o) begin
        oh = bus.user_tready_in ? gnt : '0;
        check("tready_g", bus.req_tready_o, oh);
      end
      if (acc) begin
        acc_beats++;
        acc_last = (beat[cur_g] == nbeats[cur_g] - 1);
        if (exp_q.size() == 0) check("beat_unexpected", bus.user_tvalid_o, 0);
        else begin
          e = exp_q.pop_front();
          check("tdata", bus.user_tdata_o, e.d);
          check("tkeep", bus.user_tkeep_o, e.k);
          check("tlast", bus.user_tlast_o, e.l);
        end
        if (acc_last) begin
          exp_len  = (pk_cnt + 1 != pk_exp);
          done_tmr = 3;
        end else begin
          exp_len  = (pk_cnt + 1 == pk_exp);
        end
        pk_cnt++;
      end
      done_prev = bus.nwr_done_in;
      gnt_prev  = gnt;
      if (stop_beats == 0 && dones == target) begin
        check("run_beats_left", exp_q.size(), 0);
        return;
      end
    end
    check("run_budget_dones", dones, target);
  endtask

  task automatic do_reset();
    log_rst = 1'b1;
    repeat (2) @(posedge log_clk);
    #2;
    chk_outputs_zero("rst");
    log_rst = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < NUM_REQ; r++) begin
      npkt[r] = 0; beat[r] = 0; sent[r] = 0; pushed[r] = 0; nbeats[r] = 1;
      tsz[r] = '0; adr[r] = '0;
    end
    bus.req_valid_in = '0; bus.req_addr_in = '0; bus.req_tsize_in = '0;
    bus.req_tdata_in = '0; bus.req_tkeep_in = '0; bus.req_tvalid_in = '0;
    bus.req_tlast_in = '0; bus.nwr_ready_in = 1'b1; bus.nwr_busy_in = 1'b0;
    bus.nwr_done_in = 1'b0; bus.user_tready_in = 1'b1;

    do_reset();

    // Single requester, 16-beat packet, grant one cycle after request.
    setup(0, 12'd127, 34'h2_0000_1000, 16);
    push_packet(0);
    run(0, 0, 300);
    check("gnt_latency", first_gnt_cyc, 1);

    // Two requesters always pending: strict alternation 0,1,0,1.
    do_reset();
    setup(0, 12'd7, 34'h0_0000_0100, 1);
    setup(1, 12'd7, 34'h1_0000_0200, 1);
    push_packet(0); push_packet(1); push_packet(0); push_packet(1);
    run(0, 0, 300);

    // 32 beats with tready toggling.
    setup(3, 12'd255, 34'h3_ffff_fff8, 32);
    push_packet(3);
    run(1, 0, 500);

    // Expected count reached without tlast, then late tlast.
    setup(1, 12'd15, 34'h0_1234_5678, 3);
    push_packet(1);
    run(0, 0, 200);

    // tlast one beat early.
    setup(0, 12'd263, 34'h2_abcd_0000, 32);
    push_packet(0);
    run(0, 0, 300);

    // Reset in the middle of a req 2 packet.
    setup(2, 12'd127, 34'h1_5555_0000, 16);
    push_packet(2);
    run(0, 5, 200);
    bus.nwr_done_in = 1'b0;
    log_rst = 1'b1;
    @(posedge log_clk); #2;
    chk_outputs_zero("midrst");
    exp_q.delete();
    exp_gnt_q.delete();
    for (int r = 0; r < NUM_REQ; r++) begin
      npkt[r] = 0; beat[r] = 0; sent[r] = pushed[r];
    end
    setup(0, 12'd31, 34'h0_0000_4000, 4);
    setup(2, 12'd63, 34'h0_0000_8000, 8);
    push_packet(0); push_packet(2);
    drive();
    log_rst = 1'b0;
    run(0, 0, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
